rh_bf_prog_loader: RTL
======================

RH_BF_PROG_LOADER -- requirements
Module: rh_bf_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 5, program memory address width; depth is 2^ADDR_W = 32 instructions.
REQ-002 Parameter DATA_W, default 8, instruction width as {opcode[7:5], operand[4:0]}.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 prog_mode  input  1  programming-mode request, already synchronized (ui_in[3] path).
REQ-006 rx_valid  input  1  one-cycle strobe from the UART receiver: a byte is available.
REQ-007 rx_data  input  DATA_W  received byte; valid only while rx_valid=1.
REQ-008 mem_we  output  1  program memory write strobe.
REQ-009 mem_re  output  1  program memory read strobe for write-verify.
REQ-010 mem_addr  output  ADDR_W  program memory address for write and read.
REQ-011 mem_wdata  output  DATA_W  program memory write data.
REQ-012 mem_rdata  input  DATA_W  synchronous-read data, valid the cycle after mem_re.
REQ-013 busy  output  1  loader is processing a byte (drives uo_out[1] while in programming mode).
REQ-014 prog_count  output  ADDR_W+1  number of bytes committed since programming mode was entered.
REQ-015 ovr_err  output  1  sticky: a byte arrived while busy and was dropped.
REQ-016 full_err  output  1  sticky: a byte arrived with memory full and was dropped.
REQ-017 verify_err  output  1  sticky: readback did not match the written byte.
REQ-018 cpu_hold  output  1  equals the registered prog_mode; holds the CPU out of execution.

Function
REQ-019 FSM states are IDLE, WRITE, READ and CHECK, with one state per cycle outside IDLE.
REQ-020 In IDLE with prog_mode=1, rx_valid=1 and prog_count<32, the loader latches rx_data and the write address and enters WRITE on the next cycle.
REQ-021 In WRITE: mem_we=1, mem_addr=latched address, mem_wdata=latched byte; the next state is READ.
REQ-022 In READ: mem_re=1, mem_addr=latched address, mem_we=0; the next state is CHECK.
REQ-023 In CHECK: the loader compares mem_rdata with the latched byte; on mismatch it sets verify_err; the write address and prog_count each increment by 1; the next state is IDLE.
REQ-024 Latency: for rx_valid sampled in cycle N, mem_we is high in N+1, mem_re is high in N+2 and the compare happens in N+3. busy is high in N+1..N+3 and low in N+4, when the updated prog_count is visible.
REQ-025 mem_we and mem_re are never high in the same cycle; both are 0 in IDLE; mem_addr and mem_wdata hold their last values when idle.
REQ-026 rx_valid while busy is dropped, sets ovr_err, and does not affect the operation in progress.
REQ-027 rx_valid in IDLE with prog_count=32 is dropped and sets full_err; the write address does not wrap; prog_count saturates at 32.
REQ-028 rx_valid with prog_mode=0 is ignored with no write and no flag change.
REQ-029 A rising edge of prog_mode, detected against the registered copy, clears the write address, prog_count, ovr_err, full_err and verify_err in the following cycle.
REQ-030 prog_mode falling during WRITE, READ or CHECK does not abort: the operation completes, then the FSM stays in IDLE.
REQ-031 rx_valid coincident with a prog_mode rising edge is ignored; the first accepted byte is the next strobe.

Reset
REQ-032 While rst=1: state=IDLE, write address=0, prog_count=0, and mem_we, mem_re, busy, ovr_err, full_err, verify_err, cpu_hold, mem_addr and mem_wdata are all 0.
REQ-033 rst asserted mid-operation aborts at the next clock edge with no further mem_we or mem_re; a write already issued stays in memory.

Verification
REQ-034 prog_mode=1, then the bytes 0x43, 0xC4, 0x61, 0x80, 0xFD, 0x00 spaced 10 bits apart, with a memory model -> writes at addresses 0..5 with exactly those data, prog_count=6, all error flags 0.
REQ-035 Byte 0x43 accepted, then rx_valid with 0x11 one cycle later -> ovr_err=1, only 0x43 written at addr 0, prog_count=1.
REQ-036 33 bytes with values 0x00..0x20 -> addresses 0..31 hold 0x00..0x1F, 0x20 not written, full_err=1, prog_count=32.
REQ-037 Memory model forces mem_rdata=0xFF on the readback of 0x43 -> verify_err=1 in N+4, prog_count still increments to 1.
REQ-038 rst pulsed during READ -> mem_re low from the next cycle, all outputs at their reset values; a new prog_mode rising edge plus byte 0x55 -> write at addr 0.
REQ-039 prog_mode toggled 1->0->1 after 3 bytes -> prog_count=0 and flags cleared; the next byte is written to addr 0.

Source files
------------

// File: rtl/rh_bf_prog_loader.sv
// rh_bf_prog_loader: UART byte stream to program memory loader with write-verify.
// Each accepted byte goes through WRITE, READ and CHECK, one cycle each. The
// byte is written at the next free address, read back and compared. Overruns,
// memory-full drops and verify mismatches set sticky flags. A rising edge of
// prog_mode clears the address, the count and the flags.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   prog_mode              programming-mode request (already synchronized)
//   rx_valid, rx_data      received-byte strobe and data
//   mem_we, mem_re         program memory write / read strobes
//   mem_addr, mem_wdata    program memory address and write data
//   mem_rdata              synchronous read data (valid the cycle after mem_re)
//   busy                   a byte is in flight
//   prog_count             bytes committed since programming mode was entered
//   ovr_err, full_err      sticky drop flags (arrived while busy / memory full)
//   verify_err             sticky readback mismatch flag
//   cpu_hold               registered prog_mode
module rh_bf_prog_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [ADDR_W:0]   prog_count,
  output logic              ovr_err,
  output logic              full_err,
  output logic              verify_err,
  output logic              cpu_hold
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1 << ADDR_W);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_CHECK} state_e;

  state_e              state_q, state_d;
  logic                mode_q;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;
  logic                full_q, full_d;
  logic                verify_q, verify_d;
  logic                mode_rise;
  logic                mode_on;

  // A strobe on the rising-edge cycle itself is not accepted.
  assign mode_rise = prog_mode & ~mode_q;
  assign mode_on   = prog_mode & mode_q;

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ovr_d    = ovr_q;
    full_d   = full_q;
    verify_d = verify_q;

    case (state_q)
      S_IDLE: begin
        if (mode_on && rx_valid) begin
          if (cnt_q < DEPTH) begin
            state_d = S_WRITE;
            addr_d  = waddr_q;
            wdata_d = rx_data;
          end else begin
            full_d = 1'b1;
          end
        end
      end
      S_WRITE: state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        state_d = S_IDLE;
        if (mem_rdata != wdata_q) verify_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // Hold the address on the last slot rather than wrapping to 0.
        if (cnt_q != DEPTH - 1'b1) waddr_d = waddr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Bytes arriving mid-operation are dropped without disturbing it.
    if (state_q != S_IDLE && mode_on && rx_valid) ovr_d = 1'b1;

    if (mode_rise) begin
      waddr_d  = '0;
      cnt_d    = '0;
      ovr_d    = 1'b0;
      full_d   = 1'b0;
      verify_d = 1'b0;
    end

    we_d   = (state_d == S_WRITE);
    re_d   = (state_d == S_READ);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      waddr_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      full_q   <= 1'b0;
      verify_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= prog_mode;
      waddr_q  <= waddr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      full_q   <= full_d;
      verify_q <= verify_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_re     = re_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign prog_count = cnt_q;
  assign ovr_err    = ovr_q;
  assign full_err   = full_q;
  assign verify_err = verify_q;
  assign cpu_hold   = mode_q;

endmodule
